sha3_pad_buffer: RTL and testbench
==================================

SHA3_PAD_BUFFER -- requirements
Module: sha3_pad_buffer

Interface
REQ-001 SHALL have parameter IN_W, default 32; input word width in bits, legal values 32 or 64.
REQ-002 SHALL have input port clk, 1 bit; the single clock, rising-edge active.
REQ-003 SHALL have input port reset, 1 bit; synchronous, active-high.
REQ-004 SHALL have input port mode, 2 bits; rate select: 0=1152 (224), 1=1088 (256), 2=832 (384), 3=576 (512).
REQ-005 SHALL have input port in, IN_W bits; message word, big-endian, so the first byte is in the MSBs.
REQ-006 SHALL have input port in_ready, 1 bit; in is valid this cycle.
REQ-007 SHALL have input port is_last, 1 bit; the current word is the final word.
REQ-008 SHALL have input port byte_num, clog2(IN_W/8) bits; valid bytes in the final word, range 0..IN_W/8-1.
REQ-009 SHALL have input port f_ack, 1 bit; the permutation consumed out.
REQ-010 SHALL have output port buffer_full, 1 bit; a block is held and no word can be accepted.
REQ-011 SHALL have output port out, 1152 bits; padded block, first word at out[1151 -: IN_W], bits below the rate are zero.
REQ-012 SHALL have output port out_valid, 1 bit; out holds a complete block.
REQ-013 SHALL have output port last_block, 1 bit; the valid block is the final, padded block.

Function
REQ-014 SHALL use states IDLE, FILL, FULL and DONE.
REQ-015 SHALL latch mode only in IDLE on the first accepted word; mode changes later in the message SHALL be ignored.
REQ-016 SHALL set words-per-block WPB = rate/IN_W (IN_W=32: 36/34/26/18; IN_W=64: 18/17/13/9).
REQ-017 SHALL accept a word when in_ready=1 and state is IDLE or FILL.
REQ-018 SHALL write an accepted word at word index cnt and then increment cnt.
REQ-019 SHALL ignore in_ready while state is FULL or DONE; no word is accepted and no error is raised.
REQ-020 SHALL, on a non-last word with cnt=WPB-1, go to FULL with buffer_full=1 and out_valid=1 on the next cycle and last_block=0.
REQ-021 SHALL, on an is_last word, keep the byte_num leading bytes, place the domain byte at byte offset byte_num and zero the remaining bytes of the word.
REQ-022 SHALL zero all higher word indices and OR 0x80 into the final rate byte, all in one cycle, then go to FULL with last_block=1.
REQ-023 SHALL OR the domain byte and 0x80 into one byte when they land on the same byte (0x86 or 0x81).
REQ-024 SHALL always fit padding in the is_last word, because byte_num < IN_W/8; no extra padding block exists.
REQ-025 SHALL, on is_last, ignore in bytes beyond byte_num.
REQ-026 SHALL, on is_last with byte_num=0, emit a word holding only the domain byte.
REQ-027 SHALL, in FULL with f_ack=1 and last_block=0, clear out, cnt, out_valid and buffer_full on the next cycle and go to FILL.
REQ-028 SHALL, in FULL with f_ack=1 and last_block=1, drop out_valid on the next cycle and go to DONE; DONE holds buffer_full=1 until reset.
REQ-029 SHALL ignore f_ack outside FULL.
REQ-030 SHALL, for in_ready and f_ack in the same cycle in FULL, honour f_ack and drop the word.
REQ-031 SHALL keep out stable while out_valid=1.

Reset
REQ-032 SHALL, on reset=1 at a rising edge, set state=IDLE, cnt=0, out=0, out_valid=0, buffer_full=0 and last_block=0.
REQ-033 SHALL give reset priority over in_ready and f_ack.
REQ-034 SHALL, on reset mid-message or with a block pending, discard the block; out_valid=0 on the next cycle.

Configuration
REQ-035 SHALL, with SHA3_KECCAK_LEGACY_PAD_EN defined, use domain byte 0x01 (original Keccak padding).
REQ-036 SHALL, with SHA3_KECCAK_LEGACY_PAD_EN undefined, use domain byte 0x06 (FIPS 202 SHA3).
REQ-037 SHALL leave all other behaviour identical with or without the macro.

Structure
REQ-038 SHALL place in package sha3_pad_pkg the mode enum, the rate constants table, the max rate 1152, the domain byte constant (macro-selected) and the state enum.
REQ-039 SHALL implement in combinational sub-module sha3_pad_byte_mask the keep-mask and pad-byte position for the last word from byte_num.

Verification
REQ-040 SHALL cover: IN_W=32, mode=1, "abc" as 1 word with byte_num=3 and is_last -> out[1151 -: 32]=0x61626306 and byte 135=0x80.
REQ-041 SHALL cover: IN_W=32, mode=3, 18 non-last words -> buffer_full=1 and last_block=0 after word 18; word 19 is not accepted until f_ack.
REQ-042 SHALL cover: IN_W=32, mode=3, 17 words then a last word with byte_num=3 -> final byte 0x86.
REQ-043 SHALL cover: the same as REQ-042 with SHA3_KECCAK_LEGACY_PAD_EN -> final byte 0x81.
REQ-044 SHALL cover: IN_W=64, mode=2, 5 words then reset at word 6 then "Hi" as the last word -> fresh block 0x4869060000000000.
REQ-045 SHALL cover: mode changed 0->3 after the first word -> padding still at byte 143; simultaneous in_ready+f_ack in FULL -> word dropped.

Source files
------------

// File: rtl/sha3_pad_pkg.sv
// Shared types and constants for the SHA-3 pad buffer.
//   sha3_mode_e  : rate select encoding on the mode input
//   RateTable    : rate in bits, indexed by sha3_mode_e
//   MaxRate      : widest rate (1152 bits), sets the block register width
//   DomainByte   : domain separation byte; 0x01 (original Keccak) when
//                  SHA3_KECCAK_LEGACY_PAD_EN is defined, 0x06 (FIPS 202) otherwise
//   pad_state_e  : buffer FSM states
package sha3_pad_pkg;

    typedef enum logic [1:0] {
        Mode224 = 2'd0,
        Mode256 = 2'd1,
        Mode384 = 2'd2,
        Mode512 = 2'd3
    } sha3_mode_e;

    localparam int unsigned MaxRate = 1152;
    localparam int unsigned RateW   = 11;

    // Index 0 is the rightmost element of the packed array.
    localparam logic [3:0][RateW-1:0] RateTable = '{11'd576, 11'd832, 11'd1088, 11'd1152};

`ifdef SHA3_KECCAK_LEGACY_PAD_EN
    localparam logic [7:0] DomainByte = 8'h01;
`else
    localparam logic [7:0] DomainByte = 8'h06;
`endif

    localparam logic [7:0] PadEndByte = 8'h80;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StFull,
        StDone
    } pad_state_e;

endpackage

// File: rtl/sha3_pad_byte_mask.sv
// Byte selection for the final message word.
//   byte_num_i  : number of valid message bytes in the final word
//   keep_mask_o : bit b set when byte b (b=0 is the MSB byte) carries message data
//   pad_sel_o   : one-hot, bit b set where the domain byte is placed
module sha3_pad_byte_mask #(
    parameter int unsigned IN_W = 32
) (
    input  logic [$clog2(IN_W/8)-1:0] byte_num_i,
    output logic [IN_W/8-1:0]         keep_mask_o,
    output logic [IN_W/8-1:0]         pad_sel_o
);

    localparam int unsigned BytesPerWord = IN_W / 8;
    localparam int unsigned ByteNumW     = $clog2(BytesPerWord);

    always_comb begin
        keep_mask_o = '0;
        pad_sel_o   = '0;
        for (int b = 0; b < BytesPerWord; b++) begin
            keep_mask_o[b] = ByteNumW'(b) < byte_num_i;
            pad_sel_o[b]   = ByteNumW'(b) == byte_num_i;
        end
    end

endmodule

// File: rtl/sha3_pad_buffer.sv
// Collects big-endian message words into one SHA-3 rate block and applies
// pad10*1 with the domain byte on the final word.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   mode         : rate select, latched on the first word of a message
//   in, in_ready : message word and its valid strobe
//   is_last      : current word is the final one; byte_num gives its valid bytes
//   f_ack        : permutation has consumed the block on out
//   buffer_full  : no word can be accepted
//   out          : block, first word at the MSBs; out_valid marks it complete
//   last_block   : the held block is the final, padded one
// Configuration: SHA3_KECCAK_LEGACY_PAD_EN selects the original Keccak domain byte.
module sha3_pad_buffer
    import sha3_pad_pkg::*;
#(
    parameter int unsigned IN_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic [IN_W-1:0]           in,
    input  logic                      in_ready,
    input  logic                      is_last,
    input  logic [$clog2(IN_W/8)-1:0] byte_num,
    input  logic                      f_ack,
    output logic                      buffer_full,
    output logic [MaxRate-1:0]        out,
    output logic                      out_valid,
    output logic                      last_block
);

    localparam int unsigned BytesPerWord = IN_W / 8;
    localparam int unsigned MaxWords     = MaxRate / IN_W;
    localparam int unsigned CntW         = $clog2(MaxWords + 1);
    localparam int unsigned WordShift    = $clog2(IN_W);

    pad_state_e          state_q, state_d;
    sha3_mode_e          mode_q, mode_d, eff_mode;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [MaxRate-1:0]  out_q, out_d;
    logic                last_q, last_d;

    logic [RateW-1:0]    rate, wpb, rate_bytes;
    logic                accept, block_end;
    logic [IN_W-1:0]     last_word;
    logic [BytesPerWord-1:0] keep_mask, pad_sel;

    // The live mode input only matters for the first word of a message.
    assign eff_mode   = (state_q == StIdle) ? sha3_mode_e'(mode) : mode_q;
    assign rate       = RateTable[eff_mode];
    assign wpb        = rate >> WordShift;
    assign rate_bytes = rate >> 3;
    assign accept     = in_ready && ((state_q == StIdle) || (state_q == StFill));
    assign block_end  = RateW'(cnt_q) == (wpb - RateW'(1));

    sha3_pad_byte_mask #(
        .IN_W(IN_W)
    ) u_byte_mask (
        .byte_num_i (byte_num),
        .keep_mask_o(keep_mask),
        .pad_sel_o  (pad_sel)
    );

    always_comb begin
        last_word = '0;
        for (int b = 0; b < BytesPerWord; b++) begin
            if (keep_mask[b]) begin
                last_word[IN_W-1-8*b -: 8] = in[IN_W-1-8*b -: 8];
            end else if (pad_sel[b]) begin
                last_word[IN_W-1-8*b -: 8] = DomainByte;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StFill: begin
                if (accept) begin
                    state_d = (is_last || block_end) ? StFull : StFill;
                end
            end
            StFull: begin
                if (f_ack) begin
                    state_d = last_q ? StDone : StFill;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        buffer_full = (state_q == StFull) || (state_q == StDone);
        out_valid   = (state_q == StFull);
    end

    assign out        = out_q;
    assign last_block = last_q;

    always_comb begin
        out_d  = out_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        last_d = last_q;
        if (accept) begin
            if (state_q == StIdle) begin
                mode_d = eff_mode;
            end
            cnt_d  = cnt_q + CntW'(1);
            last_d = is_last;
            for (int w = 0; w < MaxWords; w++) begin
                if (CntW'(w) == cnt_q) begin
                    out_d[MaxRate-1-w*IN_W -: IN_W] = is_last ? last_word : in;
                end else if (is_last && (CntW'(w) > cnt_q)) begin
                    out_d[MaxRate-1-w*IN_W -: IN_W] = '0;
                end
            end
            // Final rate byte may coincide with the domain byte; OR merges them.
            if (is_last) begin
                for (int k = 0; k < MaxRate / 8; k++) begin
                    if (RateW'(k) == (rate_bytes - RateW'(1))) begin
                        out_d[MaxRate-1-8*k -: 8] = out_d[MaxRate-1-8*k -: 8] | PadEndByte;
                    end
                end
            end
        end else if ((state_q == StFull) && f_ack && !last_q) begin
            out_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            cnt_q  <= '0;
            mode_q <= Mode224;
            last_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            last_q <= last_d;
        end
    end

endmodule

// File: tb/tb_sha3_pad_buffer.sv
// Directed bench for sha3_pad_buffer: one IN_W=32 and one IN_W=64 instance.
module tb_sha3_pad_buffer;

`ifdef SHA3_KECCAK_LEGACY_PAD_EN
    localparam logic [7:0] ExpDom = 8'h01;
`else
    localparam logic [7:0] ExpDom = 8'h06;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // IN_W = 32 instance
    logic          a_rst, a_ready, a_last, a_ack;
    logic [1:0]    a_mode, a_bnum;
    logic [31:0]   a_in;
    logic          a_full, a_valid, a_lastblk;
    logic [1151:0] a_out;

    // IN_W = 64 instance
    logic          b_rst, b_ready, b_last, b_ack;
    logic [1:0]    b_mode;
    logic [2:0]    b_bnum;
    logic [63:0]   b_in;
    logic          b_full, b_valid, b_lastblk;
    logic [1151:0] b_out;

    sha3_pad_buffer #(.IN_W(32)) u_dut32 (
        .clk        (clk),
        .reset      (a_rst),
        .mode       (a_mode),
        .in         (a_in),
        .in_ready   (a_ready),
        .is_last    (a_last),
        .byte_num   (a_bnum),
        .f_ack      (a_ack),
        .buffer_full(a_full),
        .out        (a_out),
        .out_valid  (a_valid),
        .last_block (a_lastblk)
    );

    sha3_pad_buffer #(.IN_W(64)) u_dut64 (
        .clk        (clk),
        .reset      (b_rst),
        .mode       (b_mode),
        .in         (b_in),
        .in_ready   (b_ready),
        .is_last    (b_last),
        .byte_num   (b_bnum),
        .f_ack      (b_ack),
        .buffer_full(b_full),
        .out        (b_out),
        .out_valid  (b_valid),
        .last_block (b_lastblk)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send32(input logic [31:0] w, input logic last, input logic [1:0] bn);
        @(negedge clk);
        a_in = w; a_last = last; a_bnum = bn; a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0; a_last = 1'b0;
    endtask

    task automatic send64(input logic [63:0] w, input logic last, input logic [2:0] bn);
        @(negedge clk);
        b_in = w; b_last = last; b_bnum = bn; b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0; b_last = 1'b0;
    endtask

    task automatic ack32();
        @(negedge clk);
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
    endtask

    task automatic reset32();
        @(negedge clk);
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
    endtask

    initial begin
        a_rst = 1'b1; a_ready = 1'b0; a_last = 1'b0; a_ack = 1'b0;
        a_mode = 2'd1; a_bnum = '0; a_in = '0;
        b_rst = 1'b1; b_ready = 1'b0; b_last = 1'b0; b_ack = 1'b0;
        b_mode = 2'd2; b_bnum = '0; b_in = '0;
        repeat (2) @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0;

        // Reset state
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_full", 64'(a_full), 64'd0);
        check("rst_last", 64'(a_lastblk), 64'd0);
        check("rst_out", 64'(|a_out), 64'd0);

        // "abc", mode 1 (rate 1088, 136 bytes); junk in the unused low byte
        a_mode = 2'd1;
        send32(32'h616263FF, 1'b1, 2'd3);
        check("abc_word0", 64'(a_out[1151 -: 32]), 64'({24'h616263, ExpDom}));
        check("abc_byte135", 64'(a_out[71:64]), 64'h80);
        check("abc_mid_zero", 64'(|a_out[1119:72]), 64'd0);
        check("abc_tail_zero", 64'(|a_out[63:0]), 64'd0);
        check("abc_valid", 64'(a_valid), 64'd1);
        check("abc_lastblk", 64'(a_lastblk), 64'd1);
        check("abc_full", 64'(a_full), 64'd1);
        ack32();
        check("done_valid", 64'(a_valid), 64'd0);
        check("done_full", 64'(a_full), 64'd1);
        send32(32'h12345678, 1'b0, 2'd0);
        check("done_ignore", 64'(a_out[1151 -: 32]), 64'({24'h616263, ExpDom}));
        check("done_full2", 64'(a_full), 64'd1);

        // Mode 3: 18 full words fill a 576-bit block
        reset32();
        a_mode = 2'd3;
        for (int i = 0; i < 18; i++) begin
            send32(32'hA0000000 + 32'(i), 1'b0, 2'd0);
            check($sformatf("fill_full_%0d", i), 64'(a_full), 64'(i == 17));
        end
        check("blk_valid", 64'(a_valid), 64'd1);
        check("blk_lastblk", 64'(a_lastblk), 64'd0);
        check("blk_word0", 64'(a_out[1151 -: 32]), 64'hA0000000);
        check("blk_word17", 64'(a_out[607:576]), 64'hA0000011);
        check("blk_below_rate", 64'(|a_out[575:0]), 64'd0);
        send32(32'hDEADBEEF, 1'b0, 2'd0);
        check("full_ignore_w0", 64'(a_out[1151 -: 32]), 64'hA0000000);
        check("full_ignore_w17", 64'(a_out[607:576]), 64'hA0000011);
        check("full_ignore_valid", 64'(a_valid), 64'd1);

        // Word and f_ack together while FULL: f_ack wins, word dropped
        @(negedge clk);
        a_in = 32'hCAFEF00D; a_ready = 1'b1; a_ack = 1'b1;
        @(negedge clk);
        a_ready = 1'b0; a_ack = 1'b0;
        check("ack_valid", 64'(a_valid), 64'd0);
        check("ack_full", 64'(a_full), 64'd0);
        check("ack_out_clear", 64'(|a_out), 64'd0);

        // 17 words plus a 3-byte last word: domain byte lands on byte 71
        a_mode = 2'd0;  // ignored mid-message
        for (int i = 0; i < 17; i++) begin
            send32(32'hB0000000 + 32'(i), 1'b0, 2'd0);
        end
        send32(32'h112233FF, 1'b1, 2'd3);
        check("pad_word0", 64'(a_out[1151 -: 32]), 64'hB0000000);
        check("pad_word17", 64'(a_out[607:576]), 64'({24'h112233, ExpDom | 8'h80}));
        check("pad_lastblk", 64'(a_lastblk), 64'd1);
        check("pad_below_rate", 64'(|a_out[575:0]), 64'd0);

        // Mode 0 then 3 after the first word; byte_num=0 last word
        reset32();
        a_mode = 2'd0;
        send32(32'h01020304, 1'b0, 2'd0);
        a_mode = 2'd3;
        send32(32'hFFFFFFFF, 1'b1, 2'd0);
        check("mode_word0", 64'(a_out[1151 -: 32]), 64'h01020304);
        check("mode_word1", 64'(a_out[1119:1088]), 64'({ExpDom, 24'h0}));
        check("mode_byte143", 64'(a_out[7:0]), 64'h80);
        check("mode_byte71", 64'(a_out[583:576]), 64'h00);
        check("mode_lastblk", 64'(a_lastblk), 64'd1);

        // IN_W=64, mode 2: reset during word 6, then "Hi" as a fresh message
        for (int i = 0; i < 5; i++) begin
            send64(64'h1111111111111111 * 64'(i + 1), 1'b0, 3'd0);
        end
        check("w64_word4", b_out[1151-4*64 -: 64], 64'h5555555555555555);
        @(negedge clk);
        b_in = 64'h6666666666666666; b_ready = 1'b1; b_rst = 1'b1;
        @(negedge clk);
        b_ready = 1'b0; b_rst = 1'b0;
        check("w64_rst_valid", 64'(b_valid), 64'd0);
        check("w64_rst_out", 64'(|b_out), 64'd0);
        send64(64'h4869FFFFFFFFFFFF, 1'b1, 3'd2);
        check("w64_hi", b_out[1151 -: 64], {16'h4869, ExpDom, 40'h0});
        check("w64_byte103", 64'(b_out[327:320]), 64'h80);
        check("w64_lastblk", 64'(b_lastblk), 64'd1);
        check("w64_valid", 64'(b_valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
